// File: rtl/tile_feeder.sv
// Walks a feature map in 6x6 tile windows (step 6 or 4), fetching each window from word memory
// with zero padding outside the image, and hands each tile to the PE array over valid/ready.
module tile_feeder (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              size_type,
  input  logic [8:0]        total_height,
  input  logic [8:0]        total_width,
  input  logic [15:0]       base_addr,
  output logic              mem_rd_en,
  output logic [15:0]       mem_rd_addr,
  input  logic signed [7:0] mem_rd_data,
  output logic signed [7:0] input_tile [0:5][0:5],
  output logic              input_valid,
  input  logic              input_ready,
  output logic [8:0]        input_low_height_index,
  output logic [8:0]        input_high_height_index,
  output logic [8:0]        input_low_weight_index,
  output logic [8:0]        input_high_weight_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StPresent, StDone} state_e;

  state_e            state_q, state_d;
  logic [8:0]        h_q, h_d, w_q, w_d;
  logic [15:0]       base_q, base_d;
  logic [9:0]        step_q, step_d;
  logic [8:0]        row0_q, row0_d, col0_q, col0_d;
  logic [2:0]        r_q, r_d, c_q, c_d;
  logic [2:0]        pend_r_q, pend_r_d, pend_c_q, pend_c_d;
  logic              pend_vld_q, pend_vld_d, pend_rd_q, pend_rd_d;
  logic signed [7:0] tile_q [0:5][0:5];
  logic signed [7:0] tile_d [0:5][0:5];
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [15:0]       mem_rd_addr_q, mem_rd_addr_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [8:0]        lo_h_q, lo_h_d, hi_h_q, hi_h_d, lo_w_q, lo_w_d, hi_w_q, hi_w_d;

  logic [9:0]        row_n, col_n, row_p5, col_p5, issue_row, issue_col;
  logic [15:0]       prod;
  logic              issue;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    w_d        = w_q;
    base_d     = base_q;
    step_d     = step_q;
    row0_d     = row0_q;
    col0_d     = col0_q;
    r_d        = r_q;
    c_d        = c_q;
    lo_h_d     = lo_h_q;
    hi_h_d     = hi_h_q;
    lo_w_d     = lo_w_q;
    hi_w_d     = hi_w_q;
    row_n      = {1'b0, row0_q} + step_q;
    col_n      = {1'b0, col0_q} + step_q;
    row_p5     = {1'b0, row0_q} + 10'd5;
    col_p5     = {1'b0, col0_q} + 10'd5;
    pend_vld_d = (state_q == StFetch);
    pend_rd_d  = mem_rd_en_q;
    pend_r_d   = r_q;
    pend_c_d   = c_q;
    tile_d     = tile_q;

    // Data returns one cycle after its read; out-of-bounds slots are padded with zero.
    if (pend_vld_q) begin
      tile_d[pend_r_q][pend_c_q] = pend_rd_q ? mem_rd_data : 8'sd0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          h_d     = total_height;
          w_d     = total_width;
          base_d  = base_addr;
          step_d  = size_type ? 10'd4 : 10'd6;
          row0_d  = '0;
          col0_d  = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = (total_height == '0 || total_width == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (r_q == 3'd5 && c_q == 3'd5) begin
          state_d = StDrain;
        end else if (c_q == 3'd5) begin
          c_d = '0;
          r_d = r_q + 3'd1;
        end else begin
          c_d = c_q + 3'd1;
        end
      end
      StDrain: begin
        state_d = StPresent;
        lo_h_d  = row0_q;
        lo_w_d  = col0_q;
        hi_h_d  = (row_p5 >= {1'b0, h_q}) ? h_q - 9'd1 : row_p5[8:0];
        hi_w_d  = (col_p5 >= {1'b0, w_q}) ? w_q - 9'd1 : col_p5[8:0];
      end
      StPresent: begin
        if (input_ready) begin
          r_d = '0;
          c_d = '0;
          if (col_n >= {1'b0, w_q}) begin
            col0_d = '0;
            if (row_n >= {1'b0, h_q}) begin
              state_d = StDone;
            end else begin
              row0_d  = row_n[8:0];
              state_d = StFetch;
            end
          end else begin
            col0_d  = col_n[8:0];
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Read for the element that will be current next cycle, so the strobe is registered.
    issue_row     = {1'b0, row0_d} + {7'd0, r_d};
    issue_col     = {1'b0, col0_d} + {7'd0, c_d};
    issue         = (state_d == StFetch) && (issue_row < {1'b0, h_d}) &&
                    (issue_col < {1'b0, w_d});
    prod          = 16'(issue_row) * 16'(w_d);
    mem_rd_en_d   = issue;
    mem_rd_addr_d = issue ? base_d + prod + 16'(issue_col) : '0;
    valid_d       = (state_d == StPresent);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      h_q           <= '0;
      w_q           <= '0;
      base_q        <= '0;
      step_q        <= '0;
      row0_q        <= '0;
      col0_q        <= '0;
      r_q           <= '0;
      c_q           <= '0;
      pend_r_q      <= '0;
      pend_c_q      <= '0;
      pend_vld_q    <= 1'b0;
      pend_rd_q     <= 1'b0;
      tile_q        <= '{default: '{default: 8'sd0}};
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      lo_h_q        <= '0;
      hi_h_q        <= '0;
      lo_w_q        <= '0;
      hi_w_q        <= '0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      w_q           <= w_d;
      base_q        <= base_d;
      step_q        <= step_d;
      row0_q        <= row0_d;
      col0_q        <= col0_d;
      r_q           <= r_d;
      c_q           <= c_d;
      pend_r_q      <= pend_r_d;
      pend_c_q      <= pend_c_d;
      pend_vld_q    <= pend_vld_d;
      pend_rd_q     <= pend_rd_d;
      tile_q        <= tile_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      lo_h_q        <= lo_h_d;
      hi_h_q        <= hi_h_d;
      lo_w_q        <= lo_w_d;
      hi_w_q        <= hi_w_d;
    end
  end

  assign mem_rd_en               = mem_rd_en_q;
  assign mem_rd_addr             = mem_rd_addr_q;
  assign input_tile              = tile_q;
  assign input_valid             = valid_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign input_low_height_index  = lo_h_q;
  assign input_high_height_index = hi_h_q;
  assign input_low_weight_index  = lo_w_q;
  assign input_high_weight_index = hi_w_q;

endmodule

// File: tb/tb_tile_feeder.sv
// Directed bench for tile_feeder: a memory model answers reads one cycle late with an
// address-derived byte, and each step checks outputs against hand-derived expectations.
module tb_tile_feeder;

  logic              clk = 1'b0;
  logic              reset, start, size_type, input_ready;
  logic [8:0]        total_height, total_width;
  logic [15:0]       base_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rd_addr;
  logic signed [7:0] mem_rd_data;
  logic signed [7:0] input_tile [0:5][0:5];
  logic              input_valid, busy, done;
  logic [8:0]        lo_h, hi_h, lo_w, hi_w;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  tile_feeder dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .size_type               (size_type),
    .total_height            (total_height),
    .total_width             (total_width),
    .base_addr               (base_addr),
    .mem_rd_en               (mem_rd_en),
    .mem_rd_addr             (mem_rd_addr),
    .mem_rd_data             (mem_rd_data),
    .input_tile              (input_tile),
    .input_valid             (input_valid),
    .input_ready             (input_ready),
    .input_low_height_index  (lo_h),
    .input_high_height_index (hi_h),
    .input_low_weight_index  (lo_w),
    .input_high_weight_index (hi_w),
    .busy                    (busy),
    .done                    (done)
  );

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Junk value when no read was issued, so zero padding must come from the DUT itself.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_f(mem_rd_addr) : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tile_bad(input logic [15:0] base, input int h, input int w,
                                  input int row0, input int col0);
    int bad = 0;
    logic [15:0] a;
    logic [7:0] e;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        a = 16'(base + (row0 + r) * w + col0 + c);
        e = ((row0 + r < h) && (col0 + c < w)) ? mem_f(a) : 8'h00;
        if (input_tile[r][c] !== e) bad++;
      end
    end
    return bad;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_valid"}, input_valid, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, {lo_h, hi_h, lo_w, hi_w}, 0);
    chk({tag, "_tile"}, tile_bad(16'h0, 0, 0, 0, 0), 0);
  endtask

  // Checks the 36 FETCH cycles starting in the current cycle; optional start poke mid-fetch.
  task automatic fetch_check(input logic [15:0] base, input int h, input int w, input int row0,
                             input int col0, input int poke_at, output int nreads);
    bit inb;
    nreads = 0;
    for (int k = 0; k < 36; k++) begin
      inb = (row0 + k / 6 < h) && (col0 + k % 6 < w);
      chk("fetch_en", mem_rd_en, inb);
      if (inb) chk("fetch_addr", mem_rd_addr, 16'(base + (row0 + k / 6) * w + col0 + k % 6));
      chk("fetch_no_done", done, 0);
      if (mem_rd_en) nreads++;
      start = (k == poke_at);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic present_check(input logic [15:0] base, input int h, input int w,
                               input int row0, input int col0, input logic [35:0] idx);
    chk("present_valid", input_valid, 1);
    chk("present_rd_en", mem_rd_en, 0);
    chk("present_tile", tile_bad(base, h, w, row0, col0), 0);
    chk("present_idx", {lo_h, hi_h, lo_w, hi_w}, idx);
  endtask

  task automatic begin_pass(input logic sz, input int h, input int w, input logic [15:0] base);
    size_type    = sz;
    total_height = 9'(h);
    total_width  = 9'(w);
    base_addr    = base;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Single-tile 6x6 pass with ready high: reads base..base+35, valid at cycle 38.
  task automatic pass_6x6(input logic [15:0] base, input int poke_at);
    int nr;
    input_ready = 1'b1;
    begin_pass(1'b0, 6, 6, base);
    fetch_check(base, 6, 6, 0, 0, poke_at, nr);
    chk("p6_reads", nr, 36);
    chk("p6_drain_valid", input_valid, 0);
    chk("p6_drain_busy", busy, 1);
    tick();
    present_check(base, 6, 6, 0, 0, {9'd0, 9'd5, 9'd0, 9'd5});
    tick();
    chk("p6_done_pulse", done, 1);
    chk("p6_done_valid", input_valid, 0);
    tick();
    chk("p6_done_low", done, 0);
    chk("p6_idle_busy", busy, 0);
    tick();
    chk("p6_no_second_done", done, 0);
  endtask

  int          nr;
  int          org_r [4] = '{0, 0, 4, 4};
  int          org_c [4] = '{0, 4, 0, 4};
  logic [35:0] idx8  [4] = '{{9'd0, 9'd5, 9'd0, 9'd5}, {9'd0, 9'd5, 9'd4, 9'd7},
                            {9'd4, 9'd7, 9'd0, 9'd5}, {9'd4, 9'd7, 9'd4, 9'd7}};

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    size_type    = 1'b0;
    input_ready  = 1'b0;
    total_height = '0;
    total_width  = '0;
    base_addr    = '0;
    tick();
    tick();
    reset_check("reset");
    reset = 1'b0;
    tick();

    // 6x6 pass with a stray start pulse in FETCH cycle 10.
    pass_6x6(16'h0100, 9);

    // 8x8, 3x3 weights: four tiles, last one mostly padding.
    input_ready = 1'b1;
    begin_pass(1'b1, 8, 8, 16'h0000);
    for (int t = 0; t < 4; t++) begin
      fetch_check(16'h0000, 8, 8, org_r[t], org_c[t], -1, nr);
      tick();
      present_check(16'h0000, 8, 8, org_r[t], org_c[t], idx8[t]);
      tick();
    end
    chk("p8_last_reads", nr, 16);
    chk("p8_done", done, 1);
    tick();

    // Back-pressure: ready low for 10 PRESENT cycles.
    input_ready = 1'b0;
    begin_pass(1'b0, 6, 6, 16'h0200);
    fetch_check(16'h0200, 6, 6, 0, 0, -1, nr);
    tick();
    present_check(16'h0200, 6, 6, 0, 0, {9'd0, 9'd5, 9'd0, 9'd5});
    for (int k = 0; k < 10; k++) begin
      tick();
      present_check(16'h0200, 6, 6, 0, 0, {9'd0, 9'd5, 9'd0, 9'd5});
      chk("stall_no_done", done, 0);
    end
    input_ready = 1'b1;
    tick();
    chk("stall_done", done, 1);
    tick();

    // Zero width: straight to DONE.
    begin_pass(1'b0, 6, 0, 16'h0300);
    chk("zw_busy", busy, 1);
    chk("zw_done", done, 1);
    chk("zw_rd_en", mem_rd_en, 0);
    tick();
    chk("zw_busy_low", busy, 0);
    chk("zw_done_low", done, 0);
    chk("zw_rd_en_low", mem_rd_en, 0);

    // Reset at FETCH cycle 20 abandons the pass.
    begin_pass(1'b0, 6, 6, 16'h0100);
    repeat (19) tick();
    chk("mid_rd_en", mem_rd_en, 1);
    reset = 1'b1;
    tick();
    reset_check("midreset");
    reset = 1'b0;
    tick();
    chk("post_reset_done", done, 0);
    chk("post_reset_tile", tile_bad(16'h0, 0, 0, 0, 0), 0);
    tick();
    pass_6x6(16'h0100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
